// File: rtl/uart_rx_frame_ctrl.sv
// UART receive framing controller: [SYNC][LEN][PAYLOAD][CSUM] -> buffered, checksummed valid/ready byte stream.
// Optional UART_FRAME_STATS_EN adds saturating ok/err/drop counters.
module uart_rx_frame_ctrl #(
   parameter logic [7:0]  G_SYNC_BYTE      = 8'hA5,
   parameter int unsigned G_MAX_LEN        = 16,
   parameter int unsigned G_TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   output logic       rx_enable,
   input  logic       rx_byte_valid,
   input  logic       rx_byte_error,
   input  logic [7:0] rx_byte,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_last,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code
`ifdef UART_FRAME_STATS_EN
   ,
   output logic [15:0] stat_ok,
   output logic [15:0] stat_err,
   output logic [15:0] stat_drop
`endif
);

   localparam int unsigned LW = $clog2(G_MAX_LEN + 1);
   localparam int unsigned AW = (G_MAX_LEN > 1) ? $clog2(G_MAX_LEN) : 1;
   localparam int unsigned TW = $clog2(G_TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN} state_t;
   typedef enum logic [1:0] {E_LEN = 2'd0, E_CSUM = 2'd1, E_LINE = 2'd2, E_TIMEOUT = 2'd3} err_t;

   state_t          state_q, state_d;
   err_t            err_code_q, err_code_d, err_sel;
   logic            enable_q, vld_prev_q, err_prev_q;
   logic [LW-1:0]   len_q, len_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [7:0]      csum_q, csum_d, out_data_q, out_data_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic            frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
   logic            byte_ev, line_ev, in_frame, tmo_hit, err_set, mem_we;
   logic [7:0]      mem_q [G_MAX_LEN];

   always_comb begin
      byte_ev     = rx_byte_valid & ~vld_prev_q & enable;
      line_ev     = rx_byte_error & ~err_prev_q;
      in_frame    = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);
      tmo_hit     = (tmo_q == TW'(G_TIMEOUT_CYCLES));
      state_d     = state_q;
      len_d       = len_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      csum_d      = csum_q;
      tmo_d       = in_frame ? tmo_q + TW'(1) : '0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;
      err_set     = 1'b0;
      err_sel     = E_LEN;
      mem_we      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (byte_ev && rx_byte == G_SYNC_BYTE) begin
               state_d = S_LEN;
               tmo_d   = '0;
            end
         end
         S_LEN, S_PAYLOAD, S_CSUM: begin
            // Priority: enable drop (silent) > line error > byte > timeout.
            if (!enable) begin
               state_d = S_IDLE;
            end else if (line_ev) begin
               err_set = 1'b1;
               err_sel = E_LINE;
            end else if (byte_ev) begin
               tmo_d = '0;
               if (state_q == S_LEN) begin
                  if (rx_byte == 8'h00 || 32'(rx_byte) > G_MAX_LEN) begin
                     err_set = 1'b1;
                     err_sel = E_LEN;
                  end else begin
                     len_d    = LW'(rx_byte);
                     csum_d   = rx_byte;
                     wr_ptr_d = '0;
                     state_d  = S_PAYLOAD;
                  end
               end else if (state_q == S_PAYLOAD) begin
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + LW'(1);
                  csum_d   = csum_q ^ rx_byte;
                  if (wr_ptr_q + LW'(1) == len_q) state_d = S_CSUM;
               end else if (rx_byte == csum_q) begin
                  rd_ptr_d = '0;
                  state_d  = S_DRAIN;
               end else begin
                  err_set = 1'b1;
                  err_sel = E_CSUM;
               end
            end else if (tmo_hit) begin
               err_set = 1'b1;
               err_sel = E_TIMEOUT;
            end
         end
         S_DRAIN: begin
            if (out_valid_q && out_ready && out_last_q) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               frame_ok_d  = 1'b1;
               state_d     = S_IDLE;
            end else if ((!out_valid_q || out_ready) && rd_ptr_q != len_q) begin
               out_valid_d = 1'b1;
               out_data_d  = mem_q[rd_ptr_q[AW-1:0]];
               out_last_d  = (rd_ptr_q + LW'(1) == len_q);
               rd_ptr_d    = rd_ptr_q + LW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (err_set) begin
         frame_err_d = 1'b1;
         err_code_d  = err_sel;
         state_d     = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         enable_q    <= 1'b0;
         vld_prev_q  <= 1'b0;
         err_prev_q  <= 1'b0;
         len_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         csum_q      <= '0;
         tmo_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= E_LEN;
      end else begin
         state_q     <= state_d;
         enable_q    <= enable;
         vld_prev_q  <= rx_byte_valid;
         err_prev_q  <= rx_byte_error;
         len_q       <= len_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         csum_q      <= csum_d;
         tmo_q       <= tmo_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= rx_byte;
   end

   assign rx_enable = enable_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign frame_ok  = frame_ok_q;
   assign frame_err = frame_err_q;
   assign err_code  = err_code_q;

`ifdef UART_FRAME_STATS_EN
   logic [15:0] stat_ok_q, stat_err_q, stat_drop_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_ok_q   <= '0;
         stat_err_q  <= '0;
         stat_drop_q <= '0;
      end else begin
         if (frame_ok_d && stat_ok_q != '1) stat_ok_q <= stat_ok_q + 16'd1;
         if (frame_err_d && stat_err_q != '1) stat_err_q <= stat_err_q + 16'd1;
         if (byte_ev && state_q == S_DRAIN && stat_drop_q != '1) stat_drop_q <= stat_drop_q + 16'd1;
      end
   end

   assign stat_ok   = stat_ok_q;
   assign stat_err  = stat_err_q;
   assign stat_drop = stat_drop_q;
`endif

endmodule
